// File: rtl/uart_sync_fifo_pkg.sv
// Shared types and default sizing for the UART byte-buffer family
// (uart_rx, uart_tx, uart_sync_fifo).
package uart_fifo_pkg;

  typedef enum logic {
    FIFO_STD  = 1'b0,
    FIFO_FWFT = 1'b1
  } fifo_mode_e;

  localparam int UART_DATA_W     = 8;
  localparam int UART_FIFO_DEPTH = 16;

endpackage

// File: rtl/uart_sync_fifo_if.sv
// Host/UART side handshake bundle for uart_sync_fifo: write/read requests,
// data, occupancy and status flags.
interface uart_sync_fifo_if
  import uart_fifo_pkg::*;
#(
  parameter int DATA_W = UART_DATA_W,
  parameter int DEPTH  = UART_FIFO_DEPTH
);
  localparam int AW = $clog2(DEPTH);

  logic              wr_en;
  logic [DATA_W-1:0] data_in;
  logic              rd_en;
  logic              clr_err;
  logic [DATA_W-1:0] data_out;
  logic              data_valid;
  logic              empty;
  logic              full;
  logic              almost_full;
  logic              almost_empty;
  logic [AW:0]       count;
  logic              overflow;
  logic              underflow;

  modport master (
    output wr_en, data_in, rd_en, clr_err,
    input  data_out, data_valid, empty, full, almost_full, almost_empty,
           count, overflow, underflow
  );

  modport slave (
    input  wr_en, data_in, rd_en, clr_err,
    output data_out, data_valid, empty, full, almost_full, almost_empty,
           count, overflow, underflow
  );

endinterface

// File: rtl/uart_sync_fifo_dpram.sv
// DEPTH x DATA_W storage: one synchronous write port, one asynchronous read
// port, contents deliberately not reset.
module fifo_dpram #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [DATA_W-1:0]        rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/uart_sync_fifo.sv
// Single-clock byte FIFO with occupancy count, almost-full/empty thresholds,
// sticky overflow/underflow flags and optional first-word-fall-through reads.
module uart_sync_fifo
  import uart_fifo_pkg::*;
#(
  parameter int DATA_W     = UART_DATA_W,
  parameter int DEPTH      = UART_FIFO_DEPTH,
  parameter int AFULL_LVL  = 12,
  parameter int AEMPTY_LVL = 2,
  parameter int FWFT       = 0
) (
  input  logic                clk,
  input  logic                rst,
  uart_sync_fifo_if.slave     bus
);

  localparam int          AW       = $clog2(DEPTH);
  localparam fifo_mode_e  MODE     = (FWFT != 0) ? FIFO_FWFT : FIFO_STD;
  localparam logic [AW:0] DEPTH_C  = (AW+1)'(DEPTH);
  localparam logic [AW:0] AFULL_C  = (AW+1)'(AFULL_LVL);
  localparam logic [AW:0] AEMPTY_C = (AW+1)'(AEMPTY_LVL);
  localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_sync_fifo: DEPTH must be a power of 2 and >= 4");
  end
  if (!(AEMPTY_LVL < AFULL_LVL && AFULL_LVL <= DEPTH)) begin : g_bad_lvl
    $error("uart_sync_fifo: need AEMPTY_LVL < AFULL_LVL <= DEPTH");
  end

  logic [AW-1:0]     rd_ptr, wr_ptr;
  logic [AW:0]       count, count_next;
  logic              empty_q, full_q, afull_q, aempty_q;
  logic              ovf_q, unf_q, valid_q;
  logic [DATA_W-1:0] dout_q, rd_data;
  logic              rd_acc, wr_acc;

  // A write into a full FIFO is still accepted when a pop frees a slot this edge.
  always_comb begin
    rd_acc     = bus.rd_en & ~empty_q;
    wr_acc     = bus.wr_en & (~full_q | rd_acc);
    count_next = count;
    if (wr_acc && !rd_acc)      count_next = count + CNT_ONE;
    else if (!wr_acc && rd_acc) count_next = count - CNT_ONE;
  end

  fifo_dpram #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_mem (
    .clk     (clk),
    .wr_en   (wr_acc & ~rst),
    .wr_addr (wr_ptr),
    .wr_data (bus.data_in),
    .rd_addr (rd_ptr),
    .rd_data (rd_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      valid_q  <= 1'b0;
      dout_q   <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_acc) begin
        rd_ptr <= rd_ptr + PTR_ONE;
        dout_q <= rd_data;
      end
      valid_q  <= rd_acc;
      count    <= count_next;
      empty_q  <= (count_next == '0);
      full_q   <= (count_next == DEPTH_C);
      afull_q  <= (count_next >= AFULL_C);
      aempty_q <= (count_next <= AEMPTY_C);
      // A new error in the same cycle as clr_err keeps the flag set.
      ovf_q    <= (bus.wr_en & ~wr_acc) | (ovf_q & ~bus.clr_err);
      unf_q    <= (bus.rd_en & empty_q) | (unf_q & ~bus.clr_err);
    end
  end

  assign bus.data_out     = (MODE == FIFO_FWFT) ? rd_data  : dout_q;
  assign bus.data_valid   = (MODE == FIFO_FWFT) ? ~empty_q : valid_q;
  assign bus.empty        = empty_q;
  assign bus.full         = full_q;
  assign bus.almost_full  = afull_q;
  assign bus.almost_empty = aempty_q;
  assign bus.count        = count;
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = unf_q;

endmodule
